// File: rtl/alu_input_seq.sv
// Operand-entry sequencer: debounced keys walk the user through A, B and opcode
// entry from the slide switches, then issue a sign-extended operand set to the ALU.
module alu_input_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLOCK_50,
    input  logic        RST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [31:0] portA,
    output logic [31:0] portB,
    output logic [3:0]  aluop,
    output logic        issue,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        ISSUE   = 2'd3
    } state_t;

    logic [3:0]       key_meta;
    logic [3:0]       key_sync;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt [4];
    logic [16:0]      sw_meta;
    logic [16:0]      sw_sync;
    logic [3:0]       press;
    logic [31:0]      value;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [3:0]       op_reg;
    state_t           st;
    logic             sw_unused;

    // SW[17] has no role in operand entry
    assign sw_unused = SW[17];

    // Two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            key_meta <= 4'hF;
            key_sync <= 4'hF;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            sw_meta  <= SW[16:0];
            sw_sync  <= sw_meta;
        end
    end

    // Per-key debounce: a new level is accepted only after holding for DEBOUNCE_CYCLES
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            stable   <= 4'hF;
            stable_d <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (key_sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= key_sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press fires only on the released-to-pressed edge of the debounced level
    assign press = stable_d & ~stable;
    assign value = {{15{sw_sync[16]}}, sw_sync};
    assign state = st;

    // Entry FSM; clear > capture > re-issue > swap when presses coincide
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            st     <= LOAD_A;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            portA  <= '0;
            portB  <= '0;
            aluop  <= '0;
            issue  <= 1'b0;
        end else begin
            issue <= 1'b0;
            if (st == ISSUE) begin
                st <= LOAD_A;
            end else if (press[3]) begin
                a_reg  <= '0;
                b_reg  <= '0;
                op_reg <= '0;
                portA  <= '0;
                portB  <= '0;
                aluop  <= '0;
                st     <= LOAD_A;
            end else if (press[0]) begin
                case (st)
                    LOAD_A: begin
                        a_reg <= value;
                        st    <= LOAD_B;
                    end
                    LOAD_B: begin
                        b_reg <= value;
                        st    <= LOAD_OP;
                    end
                    default: begin
                        op_reg <= sw_sync[3:0];
                        portA  <= a_reg;
                        portB  <= b_reg;
                        aluop  <= sw_sync[3:0];
                        issue  <= 1'b1;
                        st     <= ISSUE;
                    end
                endcase
            end else if (press[2]) begin
                portA <= a_reg;
                portB <= b_reg;
                aluop <= op_reg;
                issue <= 1'b1;
                st    <= ISSUE;
            end else if (press[1] && st == LOAD_OP) begin
                a_reg <= b_reg;
                b_reg <= a_reg;
            end
        end
    end

endmodule

// File: tb/tb_alu_input_seq.sv
// Directed bench for alu_input_seq with a short debounce window.
module tb_alu_input_seq;

    logic        CLOCK_50 = 1'b0;
    logic        RST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [31:0] portA;
    logic [31:0] portB;
    logic [3:0]  aluop;
    logic        issue;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int issue_cnt = 0;
    int n0;

    alu_input_seq #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(CLOCK_50),
        .RST(RST),
        .KEY(KEY),
        .SW(SW),
        .portA(portA),
        .portB(portB),
        .aluop(aluop),
        .issue(issue),
        .state(state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (issue === 1'b1) issue_cnt++;
    end

    task automatic press_keys(input logic [3:0] mask);
        KEY = KEY & ~mask;
        repeat (10) @(posedge CLOCK_50);
        #1;
        KEY = 4'hF;
        repeat (10) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        KEY = 4'hF;
        SW  = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        RST = 1'b0;
        n0 = issue_cnt;
        repeat (20) @(posedge CLOCK_50);
        #1;
        tests++; if (portA !== 32'h0) begin fails++; $display("FAIL reset_portA got %h exp %h", portA, 32'h0); end
        tests++; if (portB !== 32'h0) begin fails++; $display("FAIL reset_portB got %h exp %h", portB, 32'h0); end
        tests++; if (aluop !== 4'h0) begin fails++; $display("FAIL reset_aluop got %h exp %h", aluop, 4'h0); end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
        tests++; if (issue_cnt - n0 !== 0) begin fails++; $display("FAIL reset_issue got %0d exp 0", issue_cnt - n0); end
    endtask

    task automatic test_entry();
        n0 = issue_cnt;
        SW = 18'h0_0005;
        press_keys(4'b0001);
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL entry_stateA got %0d exp 1", state); end
        SW = 18'h1_FFFE;
        press_keys(4'b0001);
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL entry_stateB got %0d exp 2", state); end
        tests++; if (portA !== 32'h0) begin fails++; $display("FAIL entry_hold_portA got %h exp %h", portA, 32'h0); end
        SW = 18'h0_0002;
        press_keys(4'b0001);
        tests++; if (issue_cnt - n0 !== 1) begin fails++; $display("FAIL entry_issue_cnt got %0d exp 1", issue_cnt - n0); end
        tests++; if (portA !== 32'h0000_0005) begin fails++; $display("FAIL entry_portA got %h exp %h", portA, 32'h5); end
        tests++; if (portB !== 32'hFFFF_FFFE) begin fails++; $display("FAIL entry_portB got %h exp %h", portB, 32'hFFFF_FFFE); end
        tests++; if (aluop !== 4'h2) begin fails++; $display("FAIL entry_aluop got %h exp 2", aluop); end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL entry_state got %0d exp 0", state); end
    endtask

    task automatic test_bounce();
        int k;
        bit moved;
        moved = 1'b0;
        for (int p = 0; p < 5; p++) begin
            KEY[0] = 1'b0;
            repeat (2) @(posedge CLOCK_50);
            #1;
            if (state !== 2'd0) moved = 1'b1;
            KEY[0] = 1'b1;
            repeat (2) @(posedge CLOCK_50);
            #1;
            if (state !== 2'd0) moved = 1'b1;
        end
        tests++; if (moved) begin fails++; $display("FAIL bounce_no_press got moved exp stay_0"); end
        KEY[0] = 1'b0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLOCK_50);
            #1;
            if (state === 2'd1) begin
                k = c;
                break;
            end
        end
        tests++; if (k < 5 || k > 7) begin fails++; $display("FAIL bounce_latency got %0d exp 6+-1", k); end
        repeat (15) @(posedge CLOCK_50);
        #1;
        KEY[0] = 1'b1;
        repeat (10) @(posedge CLOCK_50);
        #1;
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL bounce_single_capture got %0d exp 1", state); end
        press_keys(4'b1000);
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL clear_state got %0d exp 0", state); end
        tests++; if (portA !== 32'h0) begin fails++; $display("FAIL clear_portA got %h exp 0", portA); end
    endtask

    task automatic test_swap();
        n0 = issue_cnt;
        SW = 18'h0_0003;
        press_keys(4'b0001);
        SW = 18'h0_0007;
        press_keys(4'b0001);
        press_keys(4'b0010);
        tests++; if (state !== 2'd2) begin fails++; $display("FAIL swap_state got %0d exp 2", state); end
        SW = 18'h0_0004;
        press_keys(4'b0001);
        tests++; if (issue_cnt - n0 !== 1) begin fails++; $display("FAIL swap_issue_cnt got %0d exp 1", issue_cnt - n0); end
        tests++; if (portA !== 32'h7) begin fails++; $display("FAIL swap_portA got %h exp 7", portA); end
        tests++; if (portB !== 32'h3) begin fails++; $display("FAIL swap_portB got %h exp 3", portB); end
        tests++; if (aluop !== 4'h4) begin fails++; $display("FAIL swap_aluop got %h exp 4", aluop); end
    endtask

    task automatic test_reissue_clear();
        n0 = issue_cnt;
        press_keys(4'b0100);
        tests++; if (issue_cnt - n0 !== 1) begin fails++; $display("FAIL reissue_cnt got %0d exp 1", issue_cnt - n0); end
        tests++; if (portA !== 32'h7 || portB !== 32'h3 || aluop !== 4'h4) begin
            fails++; $display("FAIL reissue_ops got %h %h %h exp 7 3 4", portA, portB, aluop);
        end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reissue_state got %0d exp 0", state); end
        n0 = issue_cnt;
        SW = 18'h0_0009;
        press_keys(4'b1001);
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL simul_state got %0d exp 0", state); end
        tests++; if (portA !== 32'h0 || portB !== 32'h0 || aluop !== 4'h0) begin
            fails++; $display("FAIL simul_ops got %h %h %h exp 0 0 0", portA, portB, aluop);
        end
        tests++; if (issue_cnt - n0 !== 0) begin fails++; $display("FAIL simul_issue got %0d exp 0", issue_cnt - n0); end
        press_keys(4'b0100);
        tests++; if (issue_cnt - n0 !== 1 || portA !== 32'h0) begin
            fails++; $display("FAIL clear_no_capture got cnt %0d portA %h exp 1 0", issue_cnt - n0, portA);
        end
    endtask

    task automatic test_reset_mid();
        SW = 18'h0_000B;
        press_keys(4'b0001);
        SW = 18'h0_000C;
        press_keys(4'b0001);
        SW = 18'h0_0001;
        press_keys(4'b0001);
        SW = 18'h0_000D;
        press_keys(4'b0001);
        SW = 18'h0_000E;
        press_keys(4'b0001);
        tests++; if (state !== 2'd2 || portA !== 32'hB || portB !== 32'hC) begin
            fails++; $display("FAIL hold_ops got state %0d %h %h exp 2 b c", state, portA, portB);
        end
        RST = 1'b1;
        #2;
        tests++; if (portA !== 32'h0 || portB !== 32'h0 || aluop !== 4'h0 || issue !== 1'b0) begin
            fails++; $display("FAIL async_reset_ops got %h %h %h %b exp 0", portA, portB, aluop, issue);
        end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL async_reset_state got %0d exp 0", state); end
        @(negedge CLOCK_50);
        RST = 1'b0;
        @(posedge CLOCK_50);
        #1;
        n0 = issue_cnt;
        SW = 18'h0_0021;
        press_keys(4'b0001);
        SW = 18'h0_0022;
        press_keys(4'b0001);
        tests++; if (issue_cnt - n0 !== 0 || state !== 2'd2) begin
            fails++; $display("FAIL post_reset_two got cnt %0d state %0d exp 0 2", issue_cnt - n0, state);
        end
        SW = 18'h0_0003;
        press_keys(4'b0001);
        tests++; if (issue_cnt - n0 !== 1 || portA !== 32'h21 || portB !== 32'h22 || aluop !== 4'h3) begin
            fails++; $display("FAIL post_reset_issue got cnt %0d %h %h %h exp 1 21 22 3", issue_cnt - n0, portA, portB, aluop);
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_bounce();
        test_swap();
        test_reissue_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
